// File: rtl/reorder_buffer_mp.sv
// Multi-port reorder buffer: single dispatch, NUM_CDB completions, up to COMMIT_W in-order retirements.
// Optional macro ROB_CDB_FORWARD_EN lets lookups see same-cycle CDB broadcasts.
module reorder_buffer_mp #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 64,
  parameter int REG_W    = 5,
  parameter int NUM_CDB  = 2,
  parameter int COMMIT_W = 2,
  parameter int TAG_W    = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  logic [REG_W-1:0]              dispatch_rd,
  input  logic                          dispatch_wen,
  output logic [TAG_W-1:0]              dispatch_tag,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]     cdb_value,
  input  logic [2*TAG_W-1:0]            lookup_tag,
  output logic [1:0]                    lookup_ready,
  output logic [2*DATA_W-1:0]           lookup_value,
  output logic [COMMIT_W-1:0]           commit_valid,
  output logic [COMMIT_W*TAG_W-1:0]     commit_tag,
  output logic [COMMIT_W*REG_W-1:0]     commit_rd,
  output logic [COMMIT_W-1:0]           commit_wen,
  output logic [COMMIT_W*DATA_W-1:0]    commit_value,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic [REG_W-1:0]  ent_rd    [DEPTH];
  logic              ent_wen   [DEPTH];
  logic [DATA_W-1:0] ent_value [DEPTH];

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CNT_W-1:0]  n_retire;
  logic              accept;
  logic [DEPTH-1:0]  cdb_wr;
  logic [DATA_W-1:0] cdb_wval [DEPTH];

  // Tag t addresses entry t-1; tag 0 and out-of-range tags match nothing.
  function automatic logic tag_hit(input logic [TAG_W-1:0] tag, input int idx);
    return (tag != '0) && (int'(tag) == idx + 1);
  endfunction

  assign full           = (count == CNT_W'(DEPTH));
  assign empty          = (count == '0);
  assign dispatch_ready = !full;
  assign dispatch_tag   = TAG_W'(tail) + TAG_W'(1);
  assign accept         = dispatch_valid && dispatch_ready && !flush;

  // Scan ports high to low so the lowest-indexed port wins on a tag collision.
  always_comb begin
    cdb_wr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cdb_wval[i] = '0;
      for (int p = NUM_CDB-1; p >= 0; p--) begin
        if (cdb_valid[p] && !flush && ent_valid[i] && tag_hit(cdb_tag[p*TAG_W +: TAG_W], i)) begin
          cdb_wr[i]   = 1'b1;
          cdb_wval[i] = cdb_value[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    commit_valid = '0;
    commit_tag   = '0;
    commit_rd    = '0;
    commit_wen   = '0;
    commit_value = '0;
    n_retire     = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      automatic logic [IDX_W-1:0] idx = head + IDX_W'(k);
      automatic logic lane_ok = !flush && ent_valid[idx] && ent_done[idx];
      if (k > 0) lane_ok = lane_ok && commit_valid[k-1];
      if (lane_ok) begin
        commit_valid[k]                  = 1'b1;
        commit_tag[k*TAG_W +: TAG_W]     = TAG_W'(idx) + TAG_W'(1);
        commit_rd[k*REG_W +: REG_W]      = ent_rd[idx];
        commit_wen[k]                    = ent_wen[idx];
        commit_value[k*DATA_W +: DATA_W] = ent_value[idx];
        n_retire                         = n_retire + CNT_W'(1);
      end
    end
  end

  always_comb begin
    lookup_ready = '0;
    lookup_value = '0;
    for (int j = 0; j < 2; j++) begin
      automatic logic [TAG_W-1:0] t = lookup_tag[j*TAG_W +: TAG_W];
      for (int i = 0; i < DEPTH; i++) begin
        if (tag_hit(t, i) && ent_valid[i] && ent_done[i]) begin
          lookup_ready[j]                  = 1'b1;
          lookup_value[j*DATA_W +: DATA_W] = ent_value[i];
        end
      end
`ifdef ROB_CDB_FORWARD_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (tag_hit(t, i) && cdb_wr[i]) begin
          lookup_ready[j]                  = 1'b1;
          lookup_value[j*DATA_W +: DATA_W] = cdb_wval[i];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cdb_wr[i]) ent_done[i] <= 1'b1;
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k]) begin
          ent_valid[head + IDX_W'(k)] <= 1'b0;
          ent_done[head + IDX_W'(k)]  <= 1'b0;
        end
      end
      if (accept) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + IDX_W'(1);
      end
      head  <= head + IDX_W'(n_retire);
      count <= count + CNT_W'(accept) - n_retire;
    end
  end

  // Payload storage carries no reset; entry validity gates every use.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_rd[tail]  <= dispatch_rd;
      ent_wen[tail] <= dispatch_wen;
    end
    for (int i = 0; i < DEPTH; i++)
      if (cdb_wr[i]) ent_value[i] <= cdb_wval[i];
  end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed bench for reorder_buffer_mp; commits are checked by a scoreboard monitor.
module tb_reorder_buffer_mp;
  localparam int DEPTH = 16, DATA_W = 64, REG_W = 5, NUM_CDB = 2, COMMIT_W = 2;
  localparam int TAG_W = $clog2(DEPTH+1);

  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic dispatch_valid = 1'b0, dispatch_ready, dispatch_wen = 1'b0;
  logic [REG_W-1:0] dispatch_rd = '0;
  logic [TAG_W-1:0] dispatch_tag;
  logic [NUM_CDB-1:0] cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag = '0;
  logic [NUM_CDB*DATA_W-1:0] cdb_value = '0;
  logic [2*TAG_W-1:0] lookup_tag = '0;
  logic [1:0] lookup_ready;
  logic [2*DATA_W-1:0] lookup_value;
  logic [COMMIT_W-1:0] commit_valid, commit_wen;
  logic [COMMIT_W*TAG_W-1:0] commit_tag;
  logic [COMMIT_W*REG_W-1:0] commit_rd;
  logic [COMMIT_W*DATA_W-1:0] commit_value;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic full, empty;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  rd;
    logic              wen;
    logic [DATA_W-1:0] val;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer_mp #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W),
                      .NUM_CDB(NUM_CDB), .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rd(dispatch_rd), .dispatch_wen(dispatch_wen), .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .lookup_tag(lookup_tag), .lookup_ready(lookup_ready), .lookup_value(lookup_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_wen(commit_wen), .commit_value(commit_value),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    flush          = 1'b0;
    cdb_valid      = '0;
  endtask

  task automatic drive_cdb(input int port, input int tag, input logic [DATA_W-1:0] val);
    cdb_valid[port]                  = 1'b1;
    cdb_tag[port*TAG_W +: TAG_W]     = TAG_W'(tag);
    cdb_value[port*DATA_W +: DATA_W] = val;
  endtask

  task automatic do_dispatch(input int rd, input logic wen);
    dispatch_valid = 1'b1;
    dispatch_rd    = REG_W'(rd);
    dispatch_wen   = wen;
  endtask

  task automatic push_exp(input int tag, input int rd, input logic wen, input logic [DATA_W-1:0] val);
    exp_t e;
    e.tag = TAG_W'(tag);
    e.rd  = REG_W'(rd);
    e.wen = wen;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every asserted commit lane must match the oldest expected retirement.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k]) begin
          if (exp_q.size() == 0) begin
            chk("commit_unexpected", 128'(commit_tag[k*TAG_W +: TAG_W]), 128'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("commit_lane%0d", k),
                {commit_tag[k*TAG_W +: TAG_W], commit_rd[k*REG_W +: REG_W],
                 commit_wen[k], commit_value[k*DATA_W +: DATA_W]},
                {e.tag, e.rd, e.wen, e.val});
          end
        end
      end
    end
  end

  initial begin
    lookup_tag = {TAG_W'(2), TAG_W'(1)};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_ready", 128'(dispatch_ready), 128'(1));
    chk("rst_tag", 128'(dispatch_tag), 128'(1));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_commit", 128'(commit_valid), 128'(0));
    chk("rst_lookup", 128'(lookup_ready), 128'(0));
    next_cycle();
    reset = 1'b1;

    // Fill all 16 entries; only tags 1 and 2 will ever complete before the flush.
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      do_dispatch(i, i[0]);
      if (i < 2) push_exp(i + 1, i, i[0], 64'h100 + 64'(i));
      @(negedge clk);
      chk($sformatf("fill_tag%0d", i), 128'(dispatch_tag), 128'(i + 1));
      chk($sformatf("fill_ready%0d", i), 128'(dispatch_ready), 128'(1));
    end
    next_cycle();
    do_dispatch(0, 1'b0);
    drive_cdb(0, 1, 64'h100);
    drive_cdb(1, 2, 64'h101);
    @(negedge clk);
    chk("full_flag", 128'(full), 128'(1));
    chk("full_ready", 128'(dispatch_ready), 128'(0));
    chk("full_count", 128'(count), 128'(16));
    chk("full_tag_wrap", 128'(dispatch_tag), 128'(1));
    next_cycle();
    do_dispatch(0, 1'b0);
    @(negedge clk);
    chk("retire2_lanes", 128'(commit_valid), 128'(2'b11));
    chk("retire2_no_credit", 128'(dispatch_ready), 128'(0));
    next_cycle();
    do_dispatch(0, 1'b0);
    @(negedge clk);
    chk("after_retire_count", 128'(count), 128'(14));
    chk("wrap_tag1", 128'(dispatch_tag), 128'(1));
    next_cycle();
    do_dispatch(0, 1'b0);
    @(negedge clk);
    chk("wrap_count15", 128'(count), 128'(15));
    chk("wrap_tag2", 128'(dispatch_tag), 128'(2));
    next_cycle();
    do_dispatch(0, 1'b0);
    @(negedge clk);
    chk("stall_count16", 128'(count), 128'(16));
    chk("stall_ready", 128'(dispatch_ready), 128'(0));
    chk("stall_tag3", 128'(dispatch_tag), 128'(3));
    next_cycle();
    do_dispatch(0, 1'b0);
    @(negedge clk);
    chk("stall_hold16", 128'(count), 128'(16));
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("flush1_count", 128'(count), 128'(0));

    // Out-of-order completion: tag 2 first, then tag 1; both retire together.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      do_dispatch(10 + i, 1'b1);
      push_exp(i + 1, 10 + i, 1'b1, (i == 0) ? 64'hBB : (i == 1) ? 64'hAA : 64'h33);
      @(negedge clk);
      chk($sformatf("ooo_tag%0d", i), 128'(dispatch_tag), 128'(i + 1));
    end
    next_cycle();
    drive_cdb(0, 2, 64'hAA);
    @(negedge clk);
    chk("ooo_nocommit0", 128'(commit_valid), 128'(0));
    next_cycle();
    drive_cdb(1, 1, 64'hBB);
    lookup_tag = {TAG_W'(0), TAG_W'(2)};
    @(negedge clk);
    chk("ooo_nocommit1", 128'(commit_valid), 128'(0));
    chk("ooo_lookup_rdy", 128'(lookup_ready), 128'(2'b01));
    chk("ooo_lookup_val", 128'(lookup_value[DATA_W-1:0]), 128'(64'hAA));
    next_cycle();
    @(negedge clk);
    chk("ooo_commit2", 128'(commit_valid), 128'(2'b11));
    next_cycle();
    @(negedge clk);
    chk("ooo_hold3", 128'(commit_valid), 128'(0));
    chk("ooo_count1", 128'(count), 128'(1));

    // Two ports hit tag 5 in one cycle; port 0 must win.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      do_dispatch(20 + i, 1'b0);
      push_exp(4 + i, 20 + i, 1'b0, (i == 0) ? 64'h44 : 64'h11);
      @(negedge clk);
      chk($sformatf("dup_tag%0d", i), 128'(dispatch_tag), 128'(4 + i));
    end
    next_cycle();
    drive_cdb(0, 5, 64'h11);
    drive_cdb(1, 5, 64'h22);
    next_cycle();
    lookup_tag = {TAG_W'(0), TAG_W'(5)};
    drive_cdb(0, 3, 64'h33);
    drive_cdb(1, 4, 64'h44);
    @(negedge clk);
    chk("dup_lookup_rdy", 128'(lookup_ready), 128'(2'b01));
    chk("dup_lookup_val", 128'(lookup_value[DATA_W-1:0]), 128'(64'h11));
    next_cycle();
    @(negedge clk);
    chk("dup_commit34", 128'(commit_valid), 128'(2'b11));
    next_cycle();
    @(negedge clk);
    chk("dup_commit5", 128'(commit_valid), 128'(2'b01));
    next_cycle();
    @(negedge clk);
    chk("drain_empty", 128'(empty), 128'(1));
    chk("drain_count", 128'(count), 128'(0));

    // Six in flight with the head done; flush must suppress the pending commit.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      do_dispatch(i, 1'b1);
      if (i == 5) drive_cdb(0, 6, 64'h66);
      @(negedge clk);
      chk($sformatf("fl_tag%0d", i), 128'(dispatch_tag), 128'(6 + i));
    end
    next_cycle();
    flush = 1'b1;
    do_dispatch(1, 1'b1);
    drive_cdb(0, 7, 64'h77);
    @(negedge clk);
    chk("fl_count6", 128'(count), 128'(6));
    chk("fl_no_commit", 128'(commit_valid), 128'(0));
    next_cycle();
    lookup_tag = {TAG_W'(0), TAG_W'(7)};
    @(negedge clk);
    chk("fl_count0", 128'(count), 128'(0));
    chk("fl_empty", 128'(empty), 128'(1));
    chk("fl_tag1", 128'(dispatch_tag), 128'(1));
    chk("fl_commit0", 128'(commit_valid), 128'(0));
    chk("fl_lookup0", 128'(lookup_ready), 128'(0));

    // Same-cycle visibility of a CDB result on the lookup port.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      do_dispatch(i, 1'b0);
    end
    next_cycle();
    drive_cdb(0, 4, 64'h5);
    drive_cdb(1, 20, 64'h99);
    lookup_tag = {TAG_W'(0), TAG_W'(4)};
    @(negedge clk);
`ifdef ROB_CDB_FORWARD_EN
    chk("fwd_same_rdy", 128'(lookup_ready), 128'(2'b01));
    chk("fwd_same_val", 128'(lookup_value[DATA_W-1:0]), 128'(64'h5));
`else
    chk("fwd_same_rdy", 128'(lookup_ready), 128'(2'b00));
    chk("fwd_same_val", 128'(lookup_value[DATA_W-1:0]), 128'(0));
`endif
    next_cycle();
    @(negedge clk);
    chk("fwd_next_rdy", 128'(lookup_ready), 128'(2'b01));
    chk("fwd_next_val", 128'(lookup_value[DATA_W-1:0]), 128'(64'h5));
    chk("fwd_count", 128'(count), 128'(4));
    next_cycle();
    flush = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
